// File: rtl/dpram_fifo_ctrl.sv
// Valid/ready FIFO built on an external 64x8 dual-port RAM: port A writes, port B reads,
// and a two-entry output buffer hides the RAM's one-cycle registered read latency.
module dpram_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic              ram_we_a,
  output logic [DATA_W-1:0] ram_data_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_q_b,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W+1:0] level
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;

  logic       wr_en;
  logic       pop;
  logic       rd_issue;
  logic [1:0] occ_after;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign in_ready  = !full;
  assign wr_en     = in_valid && !full;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf0_q;
  assign pop       = out_valid && out_ready;
  assign occ_after = occ_q - {1'b0, pop};

  // Issue only if the word can land in the buffer next cycle; the registered count
  // guarantees a just-written word is never read in its own write cycle.
  assign rd_issue = !empty && (({1'b0, occ_after} + {2'b00, pend_q}) < 3'd2);

  assign ram_data_a = in_data;
  assign ram_addr_a = wr_ptr_q;
  assign ram_we_a   = wr_en;
  assign ram_data_b = '0;
  assign ram_addr_b = rd_ptr_q;
  assign ram_we_b   = 1'b0;

  assign level = (ADDR_W+2)'(cnt_q) + (ADDR_W+2)'(occ_q) + (ADDR_W+2)'(pend_q);

  always_comb begin
    wr_ptr_d = wr_en    ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_issue ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(rd_issue);
    pend_d   = rd_issue;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    if (pop) begin
      buf0_d = buf1_q;
    end
    // Returning word goes to whichever slot is the tail once this cycle's pop is applied.
    if (pend_q) begin
      if (occ_after == 2'd0) begin
        buf0_d = ram_q_b;
      end else begin
        buf1_d = ram_q_b;
      end
    end
    occ_d = occ_after + {1'b0, pend_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      occ_q    <= '0;
      buf0_q   <= '0;
      buf1_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      occ_q    <= occ_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural 64x8 dual-port RAM attached.
module tb_dpram_fifo_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 6;
  localparam int unsigned DEPTH = 64;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] ram_data_a;
  logic [AW-1:0] ram_addr_a;
  logic          ram_we_a;
  logic [DW-1:0] ram_data_b;
  logic [AW-1:0] ram_addr_b;
  logic          ram_we_b;
  logic [DW-1:0] ram_q_b;
  logic          full;
  logic          empty;
  logic [AW+1:0] level;

  dpram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_data_a(ram_data_a), .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a),
    .ram_data_b(ram_data_b), .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b),
    .ram_q_b(ram_q_b), .full(full), .empty(empty), .level(level)
  );

  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sbq[$];
  int pops, wraps, viol_we_b, viol_we_a, viol_haz;
  logic [AW+1:0] lvl_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive, sample at the falling edge, update the scoreboard after the rising edge.
  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy,
                       output logic acc, output logic pp);
    logic [DW-1:0] od;
    logic [DW-1:0] exp;
    in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge clk);
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    od  = out_data;
    lvl_seen = level;
    if (ram_we_b !== 1'b0) viol_we_b++;
    if (ram_we_a !== acc) viol_we_a++;
    if (ram_we_a && (ram_addr_a == ram_addr_b) && !empty) viol_haz++;
    if (acc && ram_addr_a == AW'(DEPTH - 1)) wraps++;
    @(posedge clk);
    #1;
    if (acc) sbq.push_back(d);
    if (pp) begin
      pops++;
      chk("pop_expected", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        exp = sbq.pop_front();
        chk("pop_data", 32'(od), 32'(exp));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    pops = 0; wraps = 0; viol_we_b = 0; viol_we_a = 0; viol_haz = 0;
  endtask

  typedef struct {
    logic          rst;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          ov;
    logic [DW-1:0] od;
    logic [AW+1:0] lvl;
    logic          full;
    logic          empty;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic acc, pp;
    int acc_cnt, gaps, lvl_bad, n;

    // Expected values are the state right after the rising edge that consumed the inputs.
    vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd1, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 8'd1, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 8'd2, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 8'd2, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 8'd2, 1'b0, 1'b1};
    vt[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 8'd1, 1'b0, 1'b1};
    vt[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1};

    for (int i = 0; i < 12; i++) begin
      rst = vt[i].rst; in_valid = vt[i].iv; in_data = vt[i].d; out_ready = vt[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].ov));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(vt[i].lvl));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vt[i].full));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vt[i].empty));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(!vt[i].full));
      if (vt[i].ov || vt[i].rst)
        chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vt[i].od));
      if (vt[i].rst) begin
        chk($sformatf("v%0d_ram_addr_a", i), 32'(ram_addr_a), 32'd0);
        chk($sformatf("v%0d_ram_addr_b", i), 32'(ram_addr_b), 32'd0);
        chk($sformatf("v%0d_ram_we_a", i), 32'(ram_we_a), 32'd0);
        chk($sformatf("v%0d_ram_we_b", i), 32'(ram_we_b), 32'd0);
        chk($sformatf("v%0d_ram_data_b", i), 32'(ram_data_b), 32'd0);
      end
    end

    // Fill with the output stalled, then drain.
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 66; i++) begin
      cycle(1'b1, 8'(i), 1'b0, acc, pp);
      acc_cnt += int'(acc);
    end
    chk("fill_accepts", 32'(acc_cnt), 32'd66);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_level", 32'(level), 32'd66);
    cycle(1'b1, 8'hEE, 1'b0, acc, pp);
    chk("fill_reject_67th", 32'(acc), 32'd0);
    chk("fill_level_after_reject", 32'(level), 32'd66);
    cycle(1'b0, 8'h00, 1'b1, acc, pp);
    chk("drain_in_ready_rises", 32'(in_ready), 32'd1);
    n = 0;
    while ((sbq.size() > 0 || out_valid) && n < 200) begin
      cycle(1'b0, 8'h00, 1'b1, acc, pp);
      n++;
    end
    chk("drain_pops", 32'(pops), 32'd66);
    chk("drain_empty", 32'(empty), 32'd1);

    // Continuous streaming across three pointer wraps.
    do_reset();
    gaps = 0; lvl_bad = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 8'(i), 1'b1, acc, pp);
      if (i >= 3 && !pp) gaps++;
      if (i >= 3 && lvl_seen != 8'd3) lvl_bad++;
    end
    chk("stream_wr_addr", 32'(ram_addr_a), 32'd8);
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1, acc, pp);
    chk("stream_pops", 32'(pops), 32'd200);
    chk("stream_gaps", 32'(gaps), 32'd0);
    chk("stream_level_const", 32'(lvl_bad), 32'd0);
    chk("stream_wraps", 32'(wraps), 32'd3);
    chk("stream_leftover", 32'(sbq.size()), 32'd0);

    // Random valid/ready on both sides.
    do_reset();
    for (int i = 0; i < 1000; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0), acc, pp);
    n = 0;
    while ((sbq.size() > 0 || out_valid) && n < 200) begin
      cycle(1'b0, 8'h00, 1'b1, acc, pp);
      n++;
    end
    chk("rand_leftover", 32'(sbq.size()), 32'd0);
    chk("rand_we_b", 32'(viol_we_b), 32'd0);
    chk("rand_we_a", 32'(viol_we_a), 32'd0);
    chk("rand_rw_hazard", 32'(viol_haz), 32'd0);

    // Reset with 10 words held and a read in flight.
    do_reset();
    for (int i = 0; i < 11; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, acc, pp);
    cycle(1'b0, 8'h00, 1'b1, acc, pp);
    chk("midrst_level_before", 32'(level), 32'd10);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_ram_addr_a", 32'(ram_addr_a), 32'd0);
    chk("midrst_ram_addr_b", 32'(ram_addr_b), 32'd0);
    sbq.delete();
    pops = 0;
    cycle(1'b1, 8'h11, 1'b1, acc, pp);
    cycle(1'b1, 8'h22, 1'b1, acc, pp);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, acc, pp);
    chk("midrst_pops", 32'(pops), 32'd2);
    chk("midrst_leftover", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
